// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and frame helpers for the framed UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Total line bits in one frame: start, payload, optional parity, stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        int result;
        result = 1 + data_bits + stop_bits;
        if (parity != PARITY_NONE) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Parity over a zero-extended payload; unused upper bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic result;
        case (mode)
            PARITY_EVEN: result = ^data;
            PARITY_ODD:  result = ~(^data);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pointers wrap modulo DEPTH.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Next pointers, count and storage; a full FIFO refuses pushes even when popping.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter with compile-time data width, parity and stop-bit count.
module uart_tx_framed #(
    parameter int CLOCK_HZ   = 25_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          serial_out
);

    import uart_pkg::*;

    localparam int DIVISOR    = CLOCK_HZ / BAUD;
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int CNT_W      = $clog2(DIVISOR);
    localparam int IDX_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx_framed: CLOCK_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_framed: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [FRAME_BITS-1:0]  frame;
    logic [DATA_BITS-1:0]   head;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready   = ~fifo_full;
    assign busy       = (state_q == ST_SEND);
    assign serial_out = (state_q == ST_SEND) ? shift_q[0] : 1'b1;

    // Assemble the whole line frame for the FIFO head word, LSB first from bit 0.
    always_comb begin
        frame                = '1;
        frame[0]             = 1'b0;
        frame[DATA_BITS:1]   = head;
        if (PARITY != PARITY_NONE) begin
            frame[DATA_BITS+1] = parity_bit(8'(head), PARITY);
        end
    end

    // Transmit FSM: load a frame on pop, hold each bit DIVISOR cycles, chain frames back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SEND;
                    shift_d = frame;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == IDX_LAST) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = frame;
                        cnt_d   = CNT_MAX;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = CNT_MAX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench: per-cycle behavioural line model for an 8N1 instance, plus
// literal frame checks on 8N1, 7E2 and 8O1 instances.
module tb_uart_tx_framed;

    localparam int DIV   = 16;
    localparam int DEPTH = 16;
    localparam int DBITS = 8;
    localparam int PAR   = 0;
    localparam int STOPS = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] fifo_count;
    logic       busy;
    logic       serial_out;

    logic [6:0] b_data  = 7'h00;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [4:0] b_count;
    logic       b_busy;
    logic       b_serial;

    logic [7:0] c_data  = 8'h00;
    logic       c_valid = 1'b0;
    logic       c_ready;
    logic [4:0] c_count;
    logic       c_busy;
    logic       c_serial;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    uart_tx_framed #(
        .CLOCK_HZ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_count(fifo_count), .busy(busy), .serial_out(serial_out)
    );

    uart_tx_framed #(
        .CLOCK_HZ(160), .BAUD(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) u_dut_7e2 (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .fifo_count(b_count), .busy(b_busy), .serial_out(b_serial)
    );

    uart_tx_framed #(
        .CLOCK_HZ(160), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut_8o1 (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .fifo_count(c_count), .busy(c_busy), .serial_out(c_serial)
    );

    // One comparison: count it, and report any difference on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: queued words and the per-cycle line levels still to be driven.
    int unsigned mq[$];
    bit          lineq[$];
    bit          live      = 1'b0;
    bit          expSerial = 1'b1;
    bit          expBusy   = 1'b0;
    bit          mPush;

    // Expand one word into DIV copies of each frame bit.
    function automatic void appendFrame(input int unsigned w);
        bit bits[$];
        int unsigned payload;
        payload = w & ((1 << DBITS) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < DBITS; i++) begin
            bits.push_back(bit'((payload >> i) & 1));
        end
        if (PAR != 0) begin
            bits.push_back(bit'(($countones(payload) % 2) ^ ((PAR == 2) ? 1 : 0)));
        end
        for (int s = 0; s < STOPS; s++) begin
            bits.push_back(1'b1);
        end
        foreach (bits[k]) begin
            for (int c = 0; c < DIV; c++) begin
                lineq.push_back(bits[k]);
            end
        end
    endfunction

    // Advance the model at each edge, then compare all main-instance outputs just after it.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            lineq.delete();
            live      = 1'b1;
            expSerial = 1'b1;
            expBusy   = 1'b0;
        end else if (live) begin
            mPush = in_valid && (mq.size() < DEPTH);
            if (lineq.size() == 0 && mq.size() != 0) begin
                appendFrame(mq.pop_front());
            end
            if (mPush) begin
                mq.push_back(int'(in_data));
            end
            if (lineq.size() != 0) begin
                expSerial = lineq.pop_front();
                expBusy   = 1'b1;
            end else begin
                expSerial = 1'b1;
                expBusy   = 1'b0;
            end
        end
        #1;
        if (live) begin
            checkOutput("model_serial_out", 32'(serial_out), 32'(expSerial));
            checkOutput("model_busy", 32'(busy), 32'(expBusy));
            checkOutput("model_fifo_count", 32'(fifo_count), 32'(mq.size()));
            checkOutput("model_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        end
    end

    // Synchronous reset pulse lasting one rising edge.
    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random traffic on the main instance with a given valid percentage and rare resets.
    task automatic applyStimulus(input int pct, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) < pct);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 999) == 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Wait, bounded, for the main instance to finish everything queued.
    task automatic drainMain(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_count !== 5'd0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {busy, fifo_count}, 32'd0);
    endtask

    logic [9:0]  expA5;
    logic [10:0] exp35;
    int          accepted;
    int          firstDrop;
    int          firstBack;
    int          peak;
    bit          xferPending;

    initial begin
        expA5 = 10'b1101001010;
        exp35 = 11'b11001101010;

        applyReset();
        checkOutput("reset_serial_out", 32'(serial_out), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Single frames on three configurations, sampled at bit centres.
        in_valid = 1'b1; in_data = 8'hA5;
        b_valid  = 1'b1; b_data  = 7'h35;
        c_valid  = 1'b1; c_data  = 8'h00;
        for (int cyc = 1; cyc <= 340; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                in_valid = 1'b0; b_valid = 1'b0; c_data = 8'h01;
                checkOutput("a5_no_start_in_push_cycle", 32'(serial_out), 32'd1);
                checkOutput("a5_busy_in_push_cycle", 32'(busy), 32'd0);
            end
            if (cyc == 2) begin
                c_valid = 1'b0;
                checkOutput("a5_start_after_one_edge", 32'(serial_out), 32'd0);
                checkOutput("a5_busy_rises", 32'(busy), 32'd1);
            end
            if (cyc >= 10 && (cyc - 10) % 16 == 0) begin
                if ((cyc - 10) / 16 < 10) begin
                    checkOutput("a5_bit", 32'(serial_out), 32'(expA5[(cyc - 10) / 16]));
                end
                if ((cyc - 10) / 16 < 11) begin
                    checkOutput("7e2_bit", 32'(b_serial), 32'(exp35[(cyc - 10) / 16]));
                end
            end
            if (cyc == 161) checkOutput("a5_busy_last_cycle", 32'(busy), 32'd1);
            if (cyc == 162) checkOutput("a5_busy_falls", 32'(busy), 32'd0);
            if (cyc == 177) checkOutput("7e2_busy_last_cycle", 32'(b_busy), 32'd1);
            if (cyc == 178) begin
                checkOutput("7e2_busy_falls", 32'(b_busy), 32'd0);
                checkOutput("7e2_fifo_empty", 32'(b_count), 32'd0);
                checkOutput("7e2_ready", 32'(b_ready), 32'd1);
            end
            if (cyc == 154) checkOutput("8o1_parity_of_00", 32'(c_serial), 32'd1);
            if (cyc == 186) checkOutput("8o1_second_start", 32'(c_serial), 32'd0);
            if (cyc == 202) checkOutput("8o1_second_d0", 32'(c_serial), 32'd1);
            if (cyc == 330) checkOutput("8o1_parity_of_01", 32'(c_serial), 32'd0);
            if (cyc == 340) begin
                checkOutput("8o1_busy_second_frame", 32'(c_busy), 32'd1);
                checkOutput("8o1_ready", 32'(c_ready), 32'd1);
                checkOutput("8o1_count", 32'(c_count), 32'd0);
            end
        end

        // Burst of 20 words with in_valid held high.
        accepted = 0; firstDrop = 0; firstBack = 0; peak = 0; xferPending = 1'b0;
        in_valid = 1'b1; in_data = 8'h40;
        xferPending = in_ready;
        for (int cyc = 1; cyc <= 4000 && (accepted < 20 || busy !== 1'b0 || fifo_count !== 5'd0); cyc++) begin
            @(negedge clk);
            if (xferPending) begin
                accepted++;
                in_data = 8'(8'h40 + accepted);
                if (accepted == 20) in_valid = 1'b0;
            end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (firstDrop == 0 && in_ready == 1'b0) begin
                firstDrop = cyc;
                checkOutput("burst_drop_cycle", 32'(cyc), 32'd17);
                checkOutput("burst_accepted_before_drop", 32'(accepted), 32'd17);
            end else if (firstDrop != 0 && firstBack == 0 && in_ready == 1'b1) begin
                firstBack = cyc;
                checkOutput("burst_ready_returns_on_pop", 32'(cyc), 32'd162);
                checkOutput("burst_no_pushthrough", 32'(accepted), 32'd17);
            end
            if (cyc == 163) begin
                checkOutput("burst_accepted_after_pop", 32'(accepted), 32'd18);
                checkOutput("burst_full_again", 32'(in_ready), 32'd0);
            end
            xferPending = in_valid && in_ready;
        end
        checkOutput("burst_total_accepted", 32'(accepted), 32'd20);
        checkOutput("burst_peak_count", 32'(peak), 32'd16);
        drainMain("burst_drained");

        // Reset during data bit 3 with four words queued.
        in_valid = 1'b1; in_data = 8'hC3;
        for (int cyc = 1; cyc <= 230; cyc++) begin
            @(negedge clk);
            if (cyc < 5) in_data = 8'(8'hC3 + cyc);
            if (cyc == 5) in_valid = 1'b0;
            if (cyc > 5) in_data = 8'($urandom);
            if (cyc == 69) begin
                checkOutput("abort_queued_before", 32'(fifo_count), 32'd4);
                checkOutput("abort_busy_before", 32'(busy), 32'd1);
                rst = 1'b1;
            end
            if (cyc == 70) begin
                rst = 1'b0;
                checkOutput("abort_serial_out", 32'(serial_out), 32'd1);
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_fifo_count", 32'(fifo_count), 32'd0);
                checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
            end
        end
        checkOutput("abort_line_stays_high", {busy, serial_out}, 32'd1);

        // Randomised traffic against the model.
        for (int blk = 0; blk < 8; blk++) begin
            applyStimulus(int'($urandom_range(5, 90)), 700);
        end
        drainMain("random_drained");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
